// File: rtl/tictactoe_pkg.sv
// Shared types, constants and helpers for the tic-tac-toe board engine.
package tictactoe_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned CELL_W    = 2;
  localparam int unsigned BOARD_W   = NUM_CELLS * CELL_W;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned LFSR_W    = 4;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    RAND_SCAN,
    CHECK
  } board_state_t;

  // Cell indices of every winning line: rows, columns, main diagonal, anti-diagonal.
  localparam logic [IDX_W-1:0] LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Mark code owned by a player (0 = X, 1 = O).
  function automatic cell_t mark_of(input logic player);
    return player ? MARK_O : MARK_X;
  endfunction

  // Read one cell; out-of-range indices read as EMPTY.
  function automatic cell_t cell_at(input logic [BOARD_W-1:0] b,
                                    input logic [IDX_W-1:0]   idx);
    cell_t c;
    c = EMPTY;
    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      if (idx == IDX_W'(k)) c = cell_t'(b[k*CELL_W +: CELL_W]);
    end
    return c;
  endfunction

  // Return the board with one cell overwritten.
  function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] b,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input cell_t              c);
    logic [BOARD_W-1:0] r;
    r = b;
    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      if (idx == IDX_W'(k)) r[k*CELL_W +: CELL_W] = c;
    end
    return r;
  endfunction

  // True when no cell is empty.
  function automatic logic board_full(input logic [BOARD_W-1:0] b);
    logic f;
    f = 1'b1;
    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      if (b[k*CELL_W +: CELL_W] == EMPTY) f = 1'b0;
    end
    return f;
  endfunction

  // Next probe index with 8 -> 0 wrap.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_CELLS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/ttt_lfsr4.sv
// Free-running 4-bit maximal-length LFSR (x^4 + x^3 + 1) for random moves.
module ttt_lfsr4
  import tictactoe_pkg::*;
#(
  parameter logic [3:0] SEED = 4'b0001
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr_o
);

  // A zero seed would lock the register; substitute a legal one.
  localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Fibonacci shift with feedback from taps 4 and 3.
  always_comb begin
    lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  // Advance every cycle; reload the seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SAFE_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tictactoe_board.sv
// Tic-tac-toe board state and rule engine: placement, random move, win/tie check.
module tictactoe_board
  import tictactoe_pkg::*;
#(
  parameter logic [3:0] LFSR_SEED = 4'b0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               validate_play,
  input  logic               play_random,
  input  logic               check_win,
  input  logic               player,
  input  logic [IDX_W-1:0]   position,
  output logic               busy,
  output logic               play_done,
  output logic               valid,
  output logic               win_done,
  output logic               win,
  output logic               tie,
  output logic [BOARD_W-1:0] board
);

  board_state_t       state_q;
  logic [BOARD_W-1:0] board_q;
  logic               busy_q;
  logic               play_done_q;
  logic               valid_q;
  logic               win_done_q;
  logic               win_q;
  logic               tie_q;
  logic               player_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   line_q;

  logic [LFSR_W-1:0]  lfsr;
  logic [IDX_W-1:0]   start_idx_c;
  cell_t              mark_c;
  cell_t              probe_cell_c;
  logic               place_ok_c;
  logic               line_hit_c;

  ttt_lfsr4 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  // Derived combinational helpers for the current cell / line under test.
  always_comb begin
    start_idx_c  = (lfsr < LFSR_W'(NUM_CELLS)) ? IDX_W'(lfsr)
                                               : IDX_W'(lfsr - LFSR_W'(NUM_CELLS));
    mark_c       = mark_of(player_q);
    probe_cell_c = cell_at(board_q, idx_q);
    place_ok_c   = (idx_q < IDX_W'(NUM_CELLS)) && (probe_cell_c == EMPTY);
    line_hit_c   = (cell_at(board_q, LINES[line_q[2:0]][0]) == mark_c) &&
                   (cell_at(board_q, LINES[line_q[2:0]][1]) == mark_c) &&
                   (cell_at(board_q, LINES[line_q[2:0]][2]) == mark_c);
  end

  // Command FSM with registered status outputs; clear overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      board_q     <= '0;
      busy_q      <= 1'b0;
      play_done_q <= 1'b0;
      valid_q     <= 1'b0;
      win_done_q  <= 1'b0;
      win_q       <= 1'b0;
      tie_q       <= 1'b0;
      player_q    <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
    end else begin
      play_done_q <= 1'b0;
      win_done_q  <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        board_q <= '0;
        valid_q <= 1'b0;
        win_q   <= 1'b0;
        tie_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (validate_play) begin
              idx_q    <= position;
              player_q <= player;
              state_q  <= PLACE;
              busy_q   <= 1'b1;
            end else if (play_random) begin
              idx_q    <= start_idx_c;
              cnt_q    <= '0;
              player_q <= player;
              state_q  <= RAND_SCAN;
              busy_q   <= 1'b1;
            end else if (check_win) begin
              win_q    <= 1'b0;
              tie_q    <= 1'b0;
              line_q   <= '0;
              player_q <= player;
              state_q  <= CHECK;
              busy_q   <= 1'b1;
            end
          end

          PLACE: begin
            if (place_ok_c) board_q <= set_cell(board_q, idx_q, mark_c);
            valid_q     <= place_ok_c;
            play_done_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end

          RAND_SCAN: begin
            if (probe_cell_c == EMPTY) begin
              board_q     <= set_cell(board_q, idx_q, mark_c);
              valid_q     <= 1'b1;
              play_done_q <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end else if (cnt_q == IDX_W'(NUM_CELLS - 1)) begin
              valid_q     <= 1'b0;
              play_done_q <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
            end else begin
              idx_q <= next_idx(idx_q);
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end

          CHECK: begin
            if (line_q == IDX_W'(NUM_LINES)) begin
              tie_q      <= !win_q && board_full(board_q);
              win_done_q <= 1'b1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              if (line_hit_c) win_q <= 1'b1;
              line_q <= line_q + IDX_W'(1);
            end
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign play_done = play_done_q;
  assign valid     = valid_q;
  assign win_done  = win_done_q;
  assign win       = win_q;
  assign tie       = tie_q;
  assign board     = board_q;

endmodule

// File: tb/tb_tictactoe_board.sv
// Self-checking bench for tictactoe_board against a cell-array game model.
module tb_tictactoe_board;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        validate_play;
  logic        play_random;
  logic        check_win;
  logic        player;
  logic [3:0]  position;
  logic        busy;
  logic        play_done;
  logic        valid;
  logic        win_done;
  logic        win;
  logic        tie;
  logic [17:0] board;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 empty, 1 X, 2 O
  int cells [9];
  bit m_valid, m_win, m_tie;

  tictactoe_board #(.LFSR_SEED(4'b0001)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .validate_play (validate_play),
    .play_random   (play_random),
    .check_win     (check_win),
    .player        (player),
    .position      (position),
    .busy          (busy),
    .play_done     (play_done),
    .valid         (valid),
    .win_done      (win_done),
    .win           (win),
    .tie           (tie),
    .board         (board)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(cells[k]);
    return b;
  endfunction

  function automatic bit model_win(input int code);
    bit w;
    w = 0;
    for (int r = 0; r < 3; r++) begin
      if (cells[3*r] == code && cells[3*r+1] == code && cells[3*r+2] == code) w = 1;
      if (cells[r] == code && cells[r+3] == code && cells[r+6] == code) w = 1;
    end
    if (cells[0] == code && cells[4] == code && cells[8] == code) w = 1;
    if (cells[2] == code && cells[4] == code && cells[6] == code) w = 1;
    return w;
  endfunction

  function automatic bit model_full();
    bit f;
    f = 1;
    for (int k = 0; k < 9; k++) if (cells[k] == 0) f = 0;
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) cells[k] = 0;
    m_valid = 0; m_win = 0; m_tie = 0;
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_board"}, 32'(board), 32'(model_board()));
    chk({tag, "_valid"}, 32'(valid), 32'(m_valid));
    chk({tag, "_win"},   32'(win),   32'(m_win));
    chk({tag, "_tie"},   32'(tie),   32'(m_tie));
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_reset();
    check_idle_state("clear");
    chk("clear_play_done", 32'(play_done), 32'd0);
  endtask

  task automatic do_place(input int pos, input logic pl);
    @(negedge clk);
    validate_play = 1'b1; player = pl; position = 4'(pos);
    @(negedge clk);
    validate_play = 1'b0;
    chk("place_busy", 32'(busy), 32'd1);
    @(negedge clk);
    m_valid = (pos < 9) && (cells[pos] == 0);
    if (m_valid) cells[pos] = pl ? 2 : 1;
    chk("place_done", 32'(play_done), 32'd1);
    check_idle_state("place");
  endtask

  task automatic do_check(input logic pl);
    int n;
    @(negedge clk);
    check_win = 1'b1; player = pl;
    @(negedge clk);
    check_win = 1'b0;
    chk("check_busy", 32'(busy), 32'd1);
    n = 0;
    while (win_done !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    m_win = model_win(pl ? 2 : 1);
    m_tie = !m_win && model_full();
    chk("check_latency", 32'(n), 32'd9);
    chk("check_done", 32'(win_done), 32'd1);
    check_idle_state("check");
  endtask

  task automatic do_random(input logic pl);
    int  snap [9];
    int  n, changed, c;
    bit  any_empty, skip_ok;
    snap = cells;
    any_empty = !model_full();
    @(negedge clk);
    play_random = 1'b1; player = pl;
    @(negedge clk);
    play_random = 1'b0;
    chk("rand_busy", 32'(busy), 32'd1);
    n = 0;
    while (play_done !== 1'b1 && n < 12) begin
      @(negedge clk); n++;
    end
    chk("rand_done", 32'(play_done), 32'd1);
    if (any_empty) begin
      changed = 0; c = 0;
      for (int k = 0; k < 9; k++) begin
        if (int'(board[2*k +: 2]) != snap[k]) begin changed++; c = k; end
      end
      chk("rand_changed", 32'(changed), 32'd1);
      chk("rand_was_empty", 32'(snap[c]), 32'd0);
      chk("rand_mark", 32'(board[2*c +: 2]), 32'(pl ? 2 : 1));
      chk("rand_latency_le9", 32'(n >= 1 && n <= 9), 32'd1);
      // cells probed before the hit must all have been occupied
      skip_ok = 1;
      for (int j = 1; j < n && j < 9; j++) if (snap[(c - j + 9) % 9] == 0) skip_ok = 0;
      chk("rand_skip_occupied", 32'(skip_ok), 32'd1);
      cells[c] = pl ? 2 : 1;
      m_valid = 1;
    end else begin
      chk("rand_full_latency", 32'(n), 32'd9);
      m_valid = 0;
    end
    check_idle_state("rand");
  endtask

  initial begin
    int seen;
    int pat [9];
    int e;
    rst = 1'b1; clear = 1'b0; validate_play = 1'b0; play_random = 1'b0;
    check_win = 1'b0; player = 1'b0; position = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_state("reset");
    chk("reset_play_done", 32'(play_done), 32'd0);
    chk("reset_win_done",  32'(win_done),  32'd0);

    // Centre move, then the same cell by the other player
    do_place(4, 1'b0);
    chk("centre_cell", 32'(board[9:8]), 32'd1);
    do_place(4, 1'b1);
    chk("repeat_invalid", 32'(valid), 32'd0);

    // Out-of-range positions on an empty board
    do_clear();
    do_place(9, 1'b0);
    do_place(15, 1'b1);
    chk("oob_board_zero", 32'(board), 32'd0);

    // Top-row win for X
    do_clear();
    do_place(0, 1'b0); do_place(1, 1'b0); do_place(2, 1'b0);
    do_check(1'b0);
    chk("row_win_x", 32'(win), 32'd1);
    do_check(1'b1);
    chk("row_win_o", 32'(win), 32'd0);

    // Drawn board X O X / X O O / O X X
    do_clear();
    pat = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
    for (int k = 0; k < 9; k++) do_place(k, 1'(pat[k] - 1));
    do_check(1'b0);
    chk("draw_tie", 32'(tie), 32'd1);
    do_random(1'b1);

    // Eight cells filled, single hole
    for (int t = 0; t < 3; t++) begin
      do_clear();
      e = $urandom_range(0, 8);
      for (int k = 0; k < 9; k++) if (k != e) do_place(k, 1'(k % 2));
      do_random(1'($urandom_range(0, 1)));
      chk("hole_filled", 32'(board[2*e +: 2] != 2'b00), 32'd1);
    end

    // Clear aborts an in-flight check
    do_clear();
    do_place(2, 1'b1);
    @(negedge clk); check_win = 1'b1; player = 1'b1;
    @(negedge clk); check_win = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_reset();
    check_idle_state("abort");
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (win_done) seen++; end
    chk("abort_no_win_done", 32'(seen), 32'd0);

    // Placement wins over a simultaneous check
    @(negedge clk);
    validate_play = 1'b1; check_win = 1'b1; player = 1'b1; position = 4'd3;
    @(negedge clk);
    validate_play = 1'b0; check_win = 1'b0;
    chk("simul_busy", 32'(busy), 32'd1);
    @(negedge clk);
    cells[3] = 2; m_valid = 1;
    chk("simul_play_done", 32'(play_done), 32'd1);
    check_idle_state("simul");
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (win_done) seen++; end
    chk("simul_no_win_done", 32'(seen), 32'd0);

    // Asynchronous reset during a check
    @(negedge clk); check_win = 1'b1; player = 1'b0;
    @(negedge clk); check_win = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    model_reset();
    check_idle_state("midrst");
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (win_done || play_done) seen++; end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // Randomised command mix
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0:             do_clear();
        1, 2, 3, 4:    do_place(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        5, 6:          do_random(1'($urandom_range(0, 1)));
        default:       do_check(1'($urandom_range(0, 1)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tictactoe_board.md
# tictactoe_board

Board-state and rule engine for the tic-tac-toe game, sitting directly downstream of the game-control state machine. It holds the 3x3 board and executes that controller's command strobes (place a move, place a random move, check for win/tie). It returns the status flags (valid, win, tie) that drive the controller's next transitions. It also exports the packed board for the display stage.

## Interface
Parameters:
- LFSR_SEED, 4'b0001, reset value of the random-move LFSR; must be non-zero.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous new-game command; empties the board.
- validate_play  in  1  command: place `player`'s mark at `position`.
- play_random  in  1  command: place `player`'s mark in a pseudo-random empty cell.
- check_win  in  1  command: evaluate the board for a win by `player`, or a tie.
- player  in  1  0 = player X, 1 = player O; sampled with the command.
- position  in  4  target cell 0..8, row-major (0 = top-left); sampled with validate_play.
- busy  out  1  high while a multi-cycle command is in progress.
- play_done  out  1  one-cycle pulse ending a placement command.
- valid  out  1  result of the last placement; 1 = mark written.
- win_done  out  1  one-cycle pulse ending a check command.
- win  out  1  `player` owns a complete line.
- tie  out  1  no win and all nine cells occupied.
- board  out  18  cell k in bits [2k+1:2k]; 00 empty, 01 X, 10 O.

## Operation
- States: IDLE, PLACE, RAND_SCAN, CHECK.
- Commands are accepted only in IDLE; in any other state they are ignored.
- Same-cycle priority: clear > validate_play > play_random > check_win.
- clear, from any state:
  - zeroes the board, valid, win and tie;
  - returns to IDLE;
  - aborts any in-flight command with no done pulse.
- validate_play, IDLE -> PLACE:
  - If `position` < 9 and that cell is empty, write the mark and set valid = 1.
  - Otherwise the board is unchanged and valid = 0.
  - Pulse play_done, then return to IDLE.
- play_random, IDLE -> RAND_SCAN:
  - 4-bit maximal LFSR, taps x^4+x^3+1, free-running every cycle; never zero.
  - Start index = lfsr if lfsr < 9, else lfsr - 9.
  - Probe one cell per cycle, incrementing the index with 8 -> 0 wrap.
  - First empty cell found: write the mark, set valid = 1, pulse play_done.
  - Nine probes with no empty cell: valid = 0, pulse play_done.
- check_win, IDLE -> CHECK:
  - Evaluate one line per cycle in fixed order: rows 0-2 (lines 0-2), columns 0-2 (lines 3-5), main diagonal 0-4-8 (line 6), anti-diagonal 2-4-6 (line 7).
  - Win accumulates as an OR over lines where all three cells equal `player`'s code.
  - After line 7: tie = !win && no cell is 00; pulse win_done.
- valid, win and tie hold their value until the next command of the same kind, or clear.
- Starting a check clears win and tie at acceptance.
- The board can change only via PLACE, RAND_SCAN or clear.

## Timing
- Reset values:
  - state IDLE;
  - board all 00;
  - busy, play_done, valid, win_done, win, tie all 0;
  - LFSR = LFSR_SEED.
- busy is high in every state except IDLE.
- validate_play sampled at edge N: board, valid and play_done update at edge N+1, so play_done is high in cycle N+1. Idle again at N+1.
- play_random sampled at edge N: the probe of attempt i (i = 0..8) occurs at edge N+1+i. play_done is high in the cycle after the successful probe; worst case N+9.
- check_win sampled at edge N: line k is evaluated at edge N+1+k, and win_done, win and tie are valid in cycle N+9.
- Back-to-back: a new command is accepted in the same cycle a done pulse is high.
- rst mid-operation: immediate return to reset values; no done pulse.

## Structure
- Shared package tictactoe_pkg holds:
  - cell_t (EMPTY = 2'b00, MARK_X = 2'b01, MARK_O = 2'b10);
  - board_state_t enum;
  - constant LINES[8][3] of cell indices;
  - NUM_CELLS = 9.
- One sub-module: ttt_lfsr4, which provides the free-running LFSR with seed parameter.

## Test plan
- Reset, then validate_play with player 0 at position 4 -> play_done in the next cycle, valid = 1, board[9:8] = 01. Repeating the same move with player 1 -> valid = 0, board unchanged.
- validate_play at position 9 or 15 -> valid = 0, board stays 0.
- Place X at cells 0, 1, 2, then check_win with player 0 -> win_done 9 cycles later, win = 1, tie = 0. Repeating with player 1 -> win = 0.
- Fill the board X O X / X O O / O X X, then check_win -> win = 0, tie = 1. play_random on this board -> play_done after 9 probes, valid = 0.
- From reset with LFSR_SEED = 1 and eight cells filled, play_random -> the single empty cell is written, valid = 1, and latency ≤ 9.
- clear asserted mid-CHECK -> next cycle busy = 0, board = 0, and no win_done. Simultaneous validate_play + check_win in IDLE -> only the placement executes.
